mm2s_readback: RTL

MM2S_READBACK -- requirements
Module: mm2s_readback

---
 rtl/mm2s_readback_pkg.sv | 57 +++++
 rtl/mm2s_readback_if.sv | 50 +++++
 rtl/mm2s_data_checker.sv | 47 ++++
 rtl/mm2s_readback.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mm2s_readback_pkg.sv
// +--------------------------------------------------------------------------+
// | mover_pkg: datamover command/status field map, FSM states, cmd packer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mover_pkg;

   localparam int c_CMD_W        = 72;
   localparam int c_CMD_BTT_LSB  = 0;
   localparam int c_CMD_BTT_MSB  = 22;
   localparam int c_CMD_TYPE_BIT = 23;
   localparam int c_CMD_DSA_LSB  = 24;
   localparam int c_CMD_DSA_MSB  = 29;
   localparam int c_CMD_EOF_BIT  = 30;
   localparam int c_CMD_DRR_BIT  = 31;
   localparam int c_CMD_ADDR_LSB = 32;
   localparam int c_CMD_ADDR_MSB = 63;
   localparam int c_CMD_TAG_LSB  = 64;
   localparam int c_CMD_TAG_MSB  = 67;

   localparam int c_STS_OKAY_BIT   = 7;
   localparam int c_STS_SLVERR_BIT = 6;
   localparam int c_STS_DECERR_BIT = 5;
   localparam int c_STS_INTERR_BIT = 4;
   localparam int c_STS_TAG_LSB    = 0;
   localparam int c_STS_TAG_MSB    = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_DATA = 3'd2,
      ST_STS  = 3'd3,
      ST_FIN  = 3'd4
   } mover_state_t;

   // Single-descriptor incrementing read: EOF set, no realignment, DRR clear.
   function automatic logic [c_CMD_W-1:0] pack_cmd(
      input logic [3:0]  tag,
      input logic [31:0] saddr,
      input logic [22:0] btt
   );
      logic [c_CMD_W-1:0] cmd;
      cmd = '0;
      cmd[c_CMD_BTT_MSB:c_CMD_BTT_LSB]   = btt;
      cmd[c_CMD_TYPE_BIT]                = 1'b1;
      cmd[c_CMD_DSA_MSB:c_CMD_DSA_LSB]   = 6'b0;
      cmd[c_CMD_EOF_BIT]                 = 1'b1;
      cmd[c_CMD_DRR_BIT]                 = 1'b0;
      cmd[c_CMD_ADDR_MSB:c_CMD_ADDR_LSB] = saddr;
      cmd[c_CMD_TAG_MSB:c_CMD_TAG_LSB]   = tag;
      return cmd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mm2s_readback_if.sv
// +--------------------------------------------------------------------------+
// | mm2s_readback_if: command, status and read-data AXI-Stream bundle.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mm2s_readback_if;

   logic [71:0] S_AXIS_MM2S_CMD_tdata;
   logic        S_AXIS_MM2S_CMD_tvalid;
   logic        S_AXIS_MM2S_CMD_tready;

   logic [7:0]  M_AXIS_MM2S_STS_tdata;
   logic        M_AXIS_MM2S_STS_tkeep;
   logic        M_AXIS_MM2S_STS_tlast;
   logic        M_AXIS_MM2S_STS_tvalid;
   logic        M_AXIS_MM2S_STS_tready;

   logic [63:0] M_AXIS_MM2S_tdata;
   logic [7:0]  M_AXIS_MM2S_tkeep;
   logic        M_AXIS_MM2S_tlast;
   logic        M_AXIS_MM2S_tvalid;
   logic        M_AXIS_MM2S_tready;

   // master: the readback controller; slave: the datamover.
   modport master (
      output S_AXIS_MM2S_CMD_tdata, S_AXIS_MM2S_CMD_tvalid,
      input  S_AXIS_MM2S_CMD_tready,
      input  M_AXIS_MM2S_STS_tdata, M_AXIS_MM2S_STS_tkeep,
      input  M_AXIS_MM2S_STS_tlast, M_AXIS_MM2S_STS_tvalid,
      output M_AXIS_MM2S_STS_tready,
      input  M_AXIS_MM2S_tdata, M_AXIS_MM2S_tkeep,
      input  M_AXIS_MM2S_tlast, M_AXIS_MM2S_tvalid,
      output M_AXIS_MM2S_tready
   );

   modport slave (
      input  S_AXIS_MM2S_CMD_tdata, S_AXIS_MM2S_CMD_tvalid,
      output S_AXIS_MM2S_CMD_tready,
      output M_AXIS_MM2S_STS_tdata, M_AXIS_MM2S_STS_tkeep,
      output M_AXIS_MM2S_STS_tlast, M_AXIS_MM2S_STS_tvalid,
      input  M_AXIS_MM2S_STS_tready,
      output M_AXIS_MM2S_tdata, M_AXIS_MM2S_tkeep,
      output M_AXIS_MM2S_tlast, M_AXIS_MM2S_tvalid,
      input  M_AXIS_MM2S_tready
   );

endinterface

`default_nettype wire

// File: rtl/mm2s_data_checker.sv
// +--------------------------------------------------------------------------+
// | mm2s_data_checker: compares full-keep beats to the expected counter.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mm2s_data_checker (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clear,
   input  logic        i_beat,
   input  logic [7:0]  i_tkeep,
   input  logic [63:0] i_tdata,
   input  logic [63:0] i_expected,
   input  logic [31:0] i_beat_idx,
   output logic [15:0] o_mismatch_cnt,
   output logic [31:0] o_first_bad_idx
);

   logic [15:0] r_mismatch_cnt;
   logic [31:0] r_first_bad_idx;
   logic        w_miss;

   // Partial-keep beats are not compared.
   assign w_miss = i_beat && (i_tkeep == 8'hFF) && (i_tdata != i_expected);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mismatch_cnt  <= '0;
         r_first_bad_idx <= '1;
      end else if (i_clear) begin
         r_mismatch_cnt  <= '0;
         r_first_bad_idx <= '1;
      end else if (w_miss) begin
         if (r_mismatch_cnt != 16'hFFFF)
            r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
         if (r_mismatch_cnt == 16'd0)
            r_first_bad_idx <= i_beat_idx;
      end
   end

   assign o_mismatch_cnt  = r_mismatch_cnt;
   assign o_first_bad_idx = r_first_bad_idx;

endmodule

`default_nettype wire

// File: rtl/mm2s_readback.sv
// +--------------------------------------------------------------------------+
// | mm2s_readback: issues NUM_CMDS datamover reads and checks the returned   |
// | stream. Optional comparator: MM2S_READBACK_CHECK_EN. Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mm2s_readback
   import mover_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [22:0] BTT       = 23'h00_1000,
   parameter int unsigned NUM_CMDS  = 4,
   parameter logic [3:0]  TAG       = 4'hB
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic              m_axis_mm2s_cmdsts_aresetn,
   mm2s_readback_if.master   axis,
   output logic              sts_err,
   output logic              len_err,
   output logic [15:0]       mismatch_cnt,
   output logic [31:0]       first_bad_idx
);

   localparam logic [19:0] c_LAST_BEAT = 20'(BTT >> 3) - 20'd1;
   localparam logic [31:0] c_LAST_CMD  = 32'(NUM_CMDS - 1);

   mover_state_t r_state, w_state_nxt;

   logic [1:0]  r_rst_sync;
   logic [31:0] r_addr;
   logic [31:0] r_beat_idx;
   logic [63:0] r_expected;
   logic [19:0] r_cmd_beat;
   logic [31:0] r_cmd_num;
   logic        r_sts_err;
   logic        r_len_err;

   logic        w_start_acc;
   logic        w_beat;
   logic        w_last_beat;
   logic        w_sts_hs;
   logic        w_sts_bad;

   // Datamover cmd/sts reset: asserted with reset_n, released two clocks later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign m_axis_mm2s_cmdsts_aresetn = r_rst_sync[1];

   assign w_start_acc = (r_state == ST_IDLE) && start;
   assign w_beat      = (r_state == ST_DATA) && axis.M_AXIS_MM2S_tvalid;
   assign w_last_beat = (r_cmd_beat == c_LAST_BEAT);
   assign w_sts_hs    = (r_state == ST_STS) && axis.M_AXIS_MM2S_STS_tvalid;
   assign w_sts_bad   = !axis.M_AXIS_MM2S_STS_tdata[c_STS_OKAY_BIT]
                     || axis.M_AXIS_MM2S_STS_tdata[c_STS_SLVERR_BIT]
                     || axis.M_AXIS_MM2S_STS_tdata[c_STS_DECERR_BIT]
                     || axis.M_AXIS_MM2S_STS_tdata[c_STS_INTERR_BIT]
                     || (axis.M_AXIS_MM2S_STS_tdata[c_STS_TAG_MSB:c_STS_TAG_LSB] != TAG);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt                 = r_state;
      busy                        = (r_state != ST_IDLE);
      done                        = 1'b0;
      axis.S_AXIS_MM2S_CMD_tvalid = 1'b0;
      axis.S_AXIS_MM2S_CMD_tdata  = pack_cmd(TAG, r_addr, BTT);
      axis.M_AXIS_MM2S_tready     = 1'b0;
      axis.M_AXIS_MM2S_STS_tready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_CMD;
         end
         ST_CMD: begin
            axis.S_AXIS_MM2S_CMD_tvalid = 1'b1;
            if (axis.S_AXIS_MM2S_CMD_tready) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            axis.M_AXIS_MM2S_tready = 1'b1;
            if (w_beat && w_last_beat) w_state_nxt = ST_STS;
         end
         ST_STS: begin
            axis.M_AXIS_MM2S_STS_tready = 1'b1;
            if (axis.M_AXIS_MM2S_STS_tvalid)
               w_state_nxt = (r_cmd_num == c_LAST_CMD) ? ST_FIN : ST_CMD;
         end
         ST_FIN: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Beat count is fixed at BTT/8 per command; tlast only feeds len_err.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= BASE_ADDR;
         r_beat_idx <= '0;
         r_expected <= '0;
         r_cmd_beat <= '0;
         r_cmd_num  <= '0;
         r_sts_err  <= 1'b0;
         r_len_err  <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_addr     <= BASE_ADDR;
            r_beat_idx <= '0;
            r_expected <= '0;
            r_cmd_beat <= '0;
            r_cmd_num  <= '0;
            r_sts_err  <= 1'b0;
            r_len_err  <= 1'b0;
         end
         if (w_beat) begin
            r_beat_idx <= r_beat_idx + 32'd1;
            r_expected <= r_expected + 64'd1;
            r_cmd_beat <= w_last_beat ? 20'd0 : r_cmd_beat + 20'd1;
            if (axis.M_AXIS_MM2S_tlast != w_last_beat)
               r_len_err <= 1'b1;
         end
         if (w_sts_hs) begin
            if (w_sts_bad) r_sts_err <= 1'b1;
            r_addr    <= r_addr + 32'(BTT);
            r_cmd_num <= r_cmd_num + 32'd1;
         end
      end
   end

   assign sts_err = r_sts_err;
   assign len_err = r_len_err;

`ifdef MM2S_READBACK_CHECK_EN
   mm2s_data_checker u_checker (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_clear         (w_start_acc),
      .i_beat          (w_beat),
      .i_tkeep         (axis.M_AXIS_MM2S_tkeep),
      .i_tdata         (axis.M_AXIS_MM2S_tdata),
      .i_expected      (r_expected),
      .i_beat_idx      (r_beat_idx),
      .o_mismatch_cnt  (mismatch_cnt),
      .o_first_bad_idx (first_bad_idx)
   );
`else
   assign mismatch_cnt  = '0;
   assign first_bad_idx = '1;
`endif

endmodule

`default_nettype wire
